// File: rtl/vmul_dot_acc_if.sv
// ---------------------------------------------------------------------------
// vmul_dot_acc_if
//   Operand-in / result-out bundle for the vmul_dot_acc dot-product stage.
//
//   Handshake rule for both channels: a transfer happens on a rising clk edge
//   where valid && ready are both high. The producer holds valid and its data
//   stable until that edge. Neither ready nor valid depends combinationally
//   on the other side's signal in the same cycle.
//
//   Signals:
//     in_valid  - operand pair valid (producer -> block)
//     in_ready  - block can take a pair this cycle
//     a, b      - 8-bit unsigned operands
//     out_valid - dot-product result valid
//     out_ready - consumer takes the result
//     out_acc   - accumulated dot product (ACC_W bits)
//     out_ovf   - an accumulation carried out during this vector
//
//   Modports: master = producer/consumer side, slave = the block.
// ---------------------------------------------------------------------------
interface vmul_dot_acc_if #(
  parameter int ACC_W = 20
);
  logic             in_valid;
  logic             in_ready;
  logic [7:0]       a;
  logic [7:0]       b;
  logic             out_valid;
  logic             out_ready;
  logic [ACC_W-1:0] out_acc;
  logic             out_ovf;

  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, out_acc, out_ovf
  );

  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, out_acc, out_ovf
  );
endinterface

// File: rtl/vmul_dot_acc.sv
// ---------------------------------------------------------------------------
// vmul_dot_acc
//   Pipelined dot-product stage around an 8x8 Vedic (Urdhva-Tiryagbhyam)
//   multiplier. Operand pairs are registered (S1), multiplied and the 16-bit
//   product registered (S2), then added into an ACC_W-bit accumulator (S3).
//   After VEC_LEN pairs the block drains the pipeline and holds the result on
//   the output channel until it is taken.
//
//   Ports:
//     clk       - system clock, rising edge
//     rst_n     - asynchronous active-low reset
//     clr       - synchronous abort back to the post-reset state
//     bus       - vmul_dot_acc_if.slave (operand in / result out channels)
//     dbg_state - current FSM state (FILL=0, DRAIN=1, HOLD=2)
//
//   Parameters: VEC_LEN (>=1) pairs per result, ACC_W (>=16) accumulator bits.
//
//   Build option: define VMUL_ACC_SAT_EN to saturate the accumulator at
//   2^ACC_W-1 on carry out; otherwise it wraps. out_ovf is set either way.
// ---------------------------------------------------------------------------

// 8x8 unsigned Vedic multiplier, built from 2x2 and 4x4 vertical/crosswise
// blocks. Purely combinational.
module i8bit_mul (
  input  logic [7:0]  a,
  input  logic [7:0]  b,
  output logic [15:0] p
);
  function automatic logic [3:0] vedic2(input logic [1:0] x, input logic [1:0] y);
    logic [3:0] r;
    logic       c;
    r[0] = x[0] & y[0];
    r[1] = (x[1] & y[0]) ^ (x[0] & y[1]);
    c    = (x[1] & y[0]) & (x[0] & y[1]);
    r[2] = (x[1] & y[1]) ^ c;
    r[3] = (x[1] & y[1]) & c;
    return r;
  endfunction

  function automatic logic [7:0] vedic4(input logic [3:0] x, input logic [3:0] y);
    logic [3:0] q0, q1, q2, q3;
    q0 = vedic2(x[1:0], y[1:0]);
    q1 = vedic2(x[3:2], y[1:0]);
    q2 = vedic2(x[1:0], y[3:2]);
    q3 = vedic2(x[3:2], y[3:2]);
    return {4'b0, q0} + {2'b0, q1, 2'b0} + {2'b0, q2, 2'b0} + {q3, 4'b0};
  endfunction

  logic [7:0] q0, q1, q2, q3;

  always_comb begin
    q0 = vedic4(a[3:0], b[3:0]);
    q1 = vedic4(a[7:4], b[3:0]);
    q2 = vedic4(a[3:0], b[7:4]);
    q3 = vedic4(a[7:4], b[7:4]);
    p  = {8'b0, q0} + {4'b0, q1, 4'b0} + {4'b0, q2, 4'b0} + {q3, 8'b0};
  end
endmodule

module vmul_dot_acc #(
  parameter int VEC_LEN = 4,
  parameter int ACC_W   = 20
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  vmul_dot_acc_if.slave     bus,
  output logic [1:0]        dbg_state
);
  localparam int CNT_W = $clog2(VEC_LEN + 1);
  localparam logic [CNT_W-1:0] VEC_LEN_C = CNT_W'(VEC_LEN);

  localparam logic [1:0] FILL  = 2'd0;
  localparam logic [1:0] DRAIN = 2'd1;
  localparam logic [1:0] HOLD  = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [7:0]       a_q, a_d;
  logic [7:0]       b_q, b_d;
  logic             v1_q, v1_d;
  logic [15:0]      p_q, p_d;
  logic             v2_q, v2_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic             ovf_q, ovf_d;

  logic [15:0]      prod;
  logic [ACC_W:0]   sum;
  logic [CNT_W-1:0] count_inc;
  logic             accept;

  i8bit_mul u_mul (
    .a (a_q),
    .b (b_q),
    .p (prod)
  );

  // Outputs come straight from state, so in_ready never depends on in_valid
  // and out_valid never depends on out_ready.
  always_comb begin
    bus.in_ready  = (state_q == FILL);
    bus.out_valid = (state_q == HOLD);
    bus.out_acc   = (state_q == HOLD) ? acc_q : '0;
    bus.out_ovf   = (state_q == HOLD) ? ovf_q : 1'b0;
    dbg_state     = state_q;
  end

  assign accept    = bus.in_valid && (state_q == FILL);
  assign count_inc = count_q + CNT_W'(1);
  // One extra bit so the carry out of the accumulator is visible.
  assign sum       = {1'b0, acc_q} + {{(ACC_W + 1 - 16){1'b0}}, p_q};

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    a_d     = a_q;
    b_d     = b_q;
    v1_d    = 1'b0;
    p_d     = prod;
    v2_d    = v1_q;
    acc_d   = acc_q;
    ovf_d   = ovf_q;

    // S1: operand capture.
    if (accept) begin
      a_d  = bus.a;
      b_d  = bus.b;
      v1_d = 1'b1;
      if (count_q != VEC_LEN_C) count_d = count_inc;
    end

    // S3: accumulate.
    if (v2_q) begin
      acc_d = sum[ACC_W-1:0];
      if (sum[ACC_W]) begin
        ovf_d = 1'b1;
`ifdef VMUL_ACC_SAT_EN
        acc_d = '1;
`endif
      end
    end

    unique case (state_q)
      FILL: begin
        if (accept && (count_inc == VEC_LEN_C)) state_d = DRAIN;
      end
      // Both pipeline valids low means the final product is already in acc.
      DRAIN: begin
        if (!v1_q && !v2_q) state_d = HOLD;
      end
      HOLD: begin
        if (bus.out_ready) begin
          state_d = FILL;
          acc_d   = '0;
          ovf_d   = 1'b0;
          count_d = '0;
        end
      end
      default: state_d = FILL;
    endcase

    // Abort wins over everything else decided above.
    if (clr) begin
      state_d = FILL;
      count_d = '0;
      v1_d    = 1'b0;
      v2_d    = 1'b0;
      acc_d   = '0;
      ovf_d   = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= FILL;
      count_q <= '0;
      a_q     <= '0;
      b_q     <= '0;
      v1_q    <= 1'b0;
      p_q     <= '0;
      v2_q    <= 1'b0;
      acc_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      a_q     <= a_d;
      b_q     <= b_d;
      v1_q    <= v1_d;
      p_q     <= p_d;
      v2_q    <= v2_d;
      acc_q   <= acc_d;
      ovf_q   <= ovf_d;
    end
  end
endmodule

// File: tb/tb_vmul_dot_acc.sv
// ---------------------------------------------------------------------------
// tb_vmul_dot_acc
//   Three instances share clock/reset/clr and operand lines:
//     sel 0: defaults (VEC_LEN=4, ACC_W=20)
//     sel 1: ACC_W=16 for overflow behaviour
//     sel 2: VEC_LEN=1
//   Expected {ovf, acc} values are pushed when a vector is driven and popped
//   when the instance presents its result.
// ---------------------------------------------------------------------------
module tb_vmul_dot_acc;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic clr = 1'b0;
  always #5 clk = ~clk;

  logic [2:0] iv = 3'b000;
  logic [7:0] a_drv = 8'd0;
  logic [7:0] b_drv = 8'd0;
  logic       out_ready_drv = 1'b1;

  vmul_dot_acc_if #(.ACC_W(20)) bus_a ();
  vmul_dot_acc_if #(.ACC_W(16)) bus_w ();
  vmul_dot_acc_if #(.ACC_W(20)) bus_s ();

  assign bus_a.in_valid = iv[0];
  assign bus_a.a = a_drv;
  assign bus_a.b = b_drv;
  assign bus_a.out_ready = out_ready_drv;
  assign bus_w.in_valid = iv[1];
  assign bus_w.a = a_drv;
  assign bus_w.b = b_drv;
  assign bus_w.out_ready = out_ready_drv;
  assign bus_s.in_valid = iv[2];
  assign bus_s.a = a_drv;
  assign bus_s.b = b_drv;
  assign bus_s.out_ready = out_ready_drv;

  logic [1:0] dbg_a, dbg_w, dbg_s;

  vmul_dot_acc #(.VEC_LEN(4), .ACC_W(20)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .clr(clr), .bus(bus_a), .dbg_state(dbg_a));
  vmul_dot_acc #(.VEC_LEN(4), .ACC_W(16)) u_dut_w (
    .clk(clk), .rst_n(rst_n), .clr(clr), .bus(bus_w), .dbg_state(dbg_w));
  vmul_dot_acc #(.VEC_LEN(1), .ACC_W(20)) u_dut_s (
    .clk(clk), .rst_n(rst_n), .clr(clr), .bus(bus_s), .dbg_state(dbg_s));

  logic [2:0] rdy, ovl;
  assign rdy = {bus_s.in_ready, bus_w.in_ready, bus_a.in_ready};
  assign ovl = {bus_s.out_valid, bus_w.out_valid, bus_a.out_valid};

  int n_tests = 0;
  int n_fail = 0;
  logic [20:0] exp_q[$];   // {ovf, acc} for the 20-bit instances
  logic [16:0] exp16_q[$]; // {ovf, acc} for the 16-bit instance

  // ---------------- clock helpers / drivers ----------------
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic send_pair(input int sel, input logic [7:0] x, input logic [7:0] y);
    int   w;
    logic took;
    iv = 3'b000;
    iv[sel] = 1'b1;
    a_drv = x;
    b_drv = y;
    took = 1'b0;
    w = 0;
    while (!took && w < 50) begin
      took = rdy[sel];
      tick();
      w++;
    end
    iv = 3'b000;
    n_tests++;
    if (took !== 1'b1) begin
      n_fail++;
      $display("FAIL accept_timeout: sel=%0d accepted=%0b required=1", sel, took);
    end
  endtask

  task automatic bubbles(input int n);
    iv = 3'b000;
    repeat (n) tick();
  endtask

  task automatic wait_valid(input int sel, output int lat);
    lat = 0;
    while (!ovl[sel] && lat < 40) begin
      tick();
      lat++;
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    n_tests++;
    if (bus_a.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %0b required 0", bus_a.out_valid); end
    n_tests++;
    if (bus_a.out_acc !== 20'd0) begin n_fail++; $display("FAIL reset_out_acc: got %0d required 0", bus_a.out_acc); end
    n_tests++;
    if (bus_a.out_ovf !== 1'b0) begin n_fail++; $display("FAIL reset_out_ovf: got %0b required 0", bus_a.out_ovf); end
    n_tests++;
    if (rdy !== 3'b111) begin n_fail++; $display("FAIL reset_in_ready: got %b required 111", rdy); end
    n_tests++;
    if (dbg_a !== 2'd0) begin n_fail++; $display("FAIL reset_state: got %0d required 0", dbg_a); end
  endtask

  task automatic test_basic;
    int lat;
    logic [20:0] e, got;
    exp_q.push_back({1'b0, 20'd560});
    send_pair(0, 8'd3, 8'd5);
    bubbles(2);
    send_pair(0, 8'd0, 8'd200);
    bubbles(1);
    send_pair(0, 8'd17, 8'd17);
    bubbles(3);
    send_pair(0, 8'd128, 8'd2);
    wait_valid(0, lat);
    n_tests++;
    if (lat != 3) begin n_fail++; $display("FAIL basic_latency: got %0d required 3", lat); end
    e = exp_q.pop_front();
    got = {bus_a.out_ovf, bus_a.out_acc};
    n_tests++;
    if (got !== e) begin n_fail++; $display("FAIL basic_result: got ovf=%0b acc=%0d required ovf=%0b acc=%0d", got[20], got[19:0], e[20], e[19:0]); end
    tick();
    n_tests++;
    if (bus_a.out_valid !== 1'b0 || bus_a.out_acc !== 20'd0 || bus_a.in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL basic_after_hs: got valid=%0b acc=%0d ready=%0b required 0/0/1", bus_a.out_valid, bus_a.out_acc, bus_a.in_ready);
    end
  endtask

  task automatic test_back_to_back;
    int lat, rdy_hi;
    logic [20:0] e, got;
    exp_q.push_back({1'b0, 20'h3F804});
    repeat (4) send_pair(0, 8'd255, 8'd255);
    lat = 0;
    rdy_hi = 0;
    while (!bus_a.out_valid && lat < 40) begin
      if (bus_a.in_ready) rdy_hi++;
      tick();
      lat++;
    end
    if (bus_a.in_ready) rdy_hi++;
    n_tests++;
    if (lat != 3) begin n_fail++; $display("FAIL b2b_latency: got %0d required 3", lat); end
    n_tests++;
    if (rdy_hi != 0) begin n_fail++; $display("FAIL b2b_in_ready_low: got %0d high cycles required 0", rdy_hi); end
    e = exp_q.pop_front();
    got = {bus_a.out_ovf, bus_a.out_acc};
    n_tests++;
    if (got !== e) begin n_fail++; $display("FAIL b2b_result: got ovf=%0b acc=%0d required ovf=%0b acc=%0d", got[20], got[19:0], e[20], e[19:0]); end
    tick();
    n_tests++;
    if (bus_a.in_ready !== 1'b1 || bus_a.out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_release: got ready=%0b valid=%0b required 1/0", bus_a.in_ready, bus_a.out_valid);
    end
  endtask

  task automatic test_overflow;
    int lat;
    logic [16:0] e, got;
`ifdef VMUL_ACC_SAT_EN
    exp16_q.push_back({1'b1, 16'd65535});
`else
    exp16_q.push_back({1'b1, 16'd63492});
`endif
    repeat (4) send_pair(1, 8'd255, 8'd255);
    wait_valid(1, lat);
    n_tests++;
    if (lat != 3) begin n_fail++; $display("FAIL ovf_latency: got %0d required 3", lat); end
    e = exp16_q.pop_front();
    got = {bus_w.out_ovf, bus_w.out_acc};
    n_tests++;
    if (got !== e) begin n_fail++; $display("FAIL ovf_result: got ovf=%0b acc=%0d required ovf=%0b acc=%0d", got[16], got[15:0], e[16], e[15:0]); end
    tick();
    n_tests++;
    if (bus_w.out_ovf !== 1'b0 || bus_w.out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL ovf_after_hs: got ovf=%0b valid=%0b required 0/0", bus_w.out_ovf, bus_w.out_valid);
    end
    // Sticky flag must not leak into the next vector.
    exp16_q.push_back({1'b0, 16'd4});
    repeat (4) send_pair(1, 8'd1, 8'd1);
    wait_valid(1, lat);
    e = exp16_q.pop_front();
    got = {bus_w.out_ovf, bus_w.out_acc};
    n_tests++;
    if (got !== e) begin n_fail++; $display("FAIL ovf_cleared: got ovf=%0b acc=%0d required ovf=%0b acc=%0d", got[16], got[15:0], e[16], e[15:0]); end
    tick();
  endtask

  task automatic test_hold_stall;
    int lat;
    logic [20:0] e, got;
    out_ready_drv = 1'b0;
    exp_q.push_back({1'b0, 20'd80});
    repeat (4) send_pair(0, 8'd4, 8'd5);
    wait_valid(0, lat);
    e = exp_q.pop_front();
    got = {bus_a.out_ovf, bus_a.out_acc};
    n_tests++;
    if (got !== e) begin n_fail++; $display("FAIL stall_result: got ovf=%0b acc=%0d required ovf=%0b acc=%0d", got[20], got[19:0], e[20], e[19:0]); end
    iv = 3'b001;
    a_drv = 8'd9;
    b_drv = 8'd9;
    for (int i = 0; i < 5; i++) begin
      n_tests++;
      if (bus_a.out_valid !== 1'b1 || bus_a.out_acc !== 20'd80 || bus_a.in_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL stall_stable[%0d]: got valid=%0b acc=%0d ready=%0b required 1/80/0", i, bus_a.out_valid, bus_a.out_acc, bus_a.in_ready);
      end
      tick();
    end
    iv = 3'b000;
    out_ready_drv = 1'b1;
    tick();
    n_tests++;
    if (bus_a.out_valid !== 1'b0) begin n_fail++; $display("FAIL stall_release: got valid=%0b required 0", bus_a.out_valid); end
    exp_q.push_back({1'b0, 20'd4});
    repeat (4) send_pair(0, 8'd1, 8'd1);
    wait_valid(0, lat);
    e = exp_q.pop_front();
    got = {bus_a.out_ovf, bus_a.out_acc};
    n_tests++;
    if (got !== e) begin n_fail++; $display("FAIL stall_next: got ovf=%0b acc=%0d required ovf=%0b acc=%0d", got[20], got[19:0], e[20], e[19:0]); end
    tick();
  endtask

  task automatic test_reset_mid;
    int lat;
    logic [20:0] e, got;
    repeat (2) send_pair(0, 8'd10, 8'd10);
    rst_n = 1'b0;
    #1;
    n_tests++;
    if (bus_a.out_valid !== 1'b0 || bus_a.out_acc !== 20'd0 || bus_a.in_ready !== 1'b1 || dbg_a !== 2'd0) begin
      n_fail++;
      $display("FAIL midreset_outputs: got valid=%0b acc=%0d ready=%0b state=%0d required 0/0/1/0", bus_a.out_valid, bus_a.out_acc, bus_a.in_ready, dbg_a);
    end
    tick();
    rst_n = 1'b1;
    tick();
    exp_q.push_back({1'b0, 20'd24});
    repeat (4) send_pair(0, 8'd2, 8'd3);
    wait_valid(0, lat);
    e = exp_q.pop_front();
    got = {bus_a.out_ovf, bus_a.out_acc};
    n_tests++;
    if (got !== e) begin n_fail++; $display("FAIL midreset_next: got ovf=%0b acc=%0d required ovf=%0b acc=%0d", got[20], got[19:0], e[20], e[19:0]); end
    tick();
  endtask

  task automatic test_clr_drain;
    int lat, vhi;
    logic [20:0] e, got;
    repeat (4) send_pair(0, 8'd1, 8'd2);
    n_tests++;
    if (dbg_a !== 2'd1) begin n_fail++; $display("FAIL clr_in_drain: got state=%0d required 1", dbg_a); end
    clr = 1'b1;
    tick();
    clr = 1'b0;
    n_tests++;
    if (dbg_a !== 2'd0 || bus_a.out_valid !== 1'b0 || bus_a.in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL clr_state: got state=%0d valid=%0b ready=%0b required 0/0/1", dbg_a, bus_a.out_valid, bus_a.in_ready);
    end
    vhi = 0;
    repeat (5) begin
      if (bus_a.out_valid) vhi++;
      tick();
    end
    n_tests++;
    if (vhi != 0) begin n_fail++; $display("FAIL clr_no_result: got %0d valid cycles required 0", vhi); end
    exp_q.push_back({1'b0, 20'd224});
    repeat (4) send_pair(0, 8'd7, 8'd8);
    wait_valid(0, lat);
    n_tests++;
    if (lat != 3) begin n_fail++; $display("FAIL clr_latency: got %0d required 3", lat); end
    e = exp_q.pop_front();
    got = {bus_a.out_ovf, bus_a.out_acc};
    n_tests++;
    if (got !== e) begin n_fail++; $display("FAIL clr_next: got ovf=%0b acc=%0d required ovf=%0b acc=%0d", got[20], got[19:0], e[20], e[19:0]); end
    tick();
  endtask

  task automatic test_vec_len1;
    int lat;
    logic [20:0] e, got;
    exp_q.push_back({1'b0, 20'd156});
    exp_q.push_back({1'b0, 20'd20000});
    send_pair(2, 8'd12, 8'd13);
    n_tests++;
    if (dbg_s !== 2'd1) begin n_fail++; $display("FAIL len1_drain: got state=%0d required 1", dbg_s); end
    wait_valid(2, lat);
    n_tests++;
    if (lat != 3) begin n_fail++; $display("FAIL len1_latency: got %0d required 3", lat); end
    e = exp_q.pop_front();
    got = {bus_s.out_ovf, bus_s.out_acc};
    n_tests++;
    if (got !== e) begin n_fail++; $display("FAIL len1_first: got ovf=%0b acc=%0d required ovf=%0b acc=%0d", got[20], got[19:0], e[20], e[19:0]); end
    tick();
    send_pair(2, 8'd200, 8'd100);
    wait_valid(2, lat);
    e = exp_q.pop_front();
    got = {bus_s.out_ovf, bus_s.out_acc};
    n_tests++;
    if (got !== e) begin n_fail++; $display("FAIL len1_second: got ovf=%0b acc=%0d required ovf=%0b acc=%0d", got[20], got[19:0], e[20], e[19:0]); end
    tick();
  endtask

  task automatic test_random;
    int lat;
    logic [20:0] e, got;
    logic [7:0] ra[4];
    logic [7:0] rb[4];
    logic [20:0] run;
    logic        cy;
    for (int v = 0; v < 4; v++) begin
      run = '0;
      cy = 1'b0;
      for (int k = 0; k < 4; k++) begin
        ra[k] = 8'($urandom_range(0, 255));
        rb[k] = 8'($urandom_range(0, 255));
        run = {1'b0, run[19:0]} + 21'(ra[k] * rb[k]);
        if (run[20]) cy = 1'b1;
      end
      exp_q.push_back({cy, run[19:0]});
      for (int k = 0; k < 4; k++) begin
        send_pair(0, ra[k], rb[k]);
        bubbles($urandom_range(0, 2));
      end
      wait_valid(0, lat);
      e = exp_q.pop_front();
      got = {bus_a.out_ovf, bus_a.out_acc};
      n_tests++;
      if (got !== e) begin n_fail++; $display("FAIL random_vec[%0d]: got ovf=%0b acc=%0d required ovf=%0b acc=%0d", v, got[20], got[19:0], e[20], e[19:0]); end
      tick();
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_overflow();
    test_hold_stall();
    test_reset_mid();
    test_clr_drain();
    test_vec_len1();
    test_random();
    n_tests++;
    if (exp_q.size() != 0 || exp16_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_empty: got %0d/%0d left required 0/0", exp_q.size(), exp16_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
